// File: rtl/rv32_wb_pkg.sv
// Shared types for the writeback port arbiter: arbiter states, FIFO entry layout,
// and the result-mux select used for mul/div writeback.
package rv32_wb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PENDING,
    FORCE
  } wb_arb_state_e;

  typedef struct packed {
    logic        valid;
    logic [4:0]  rd;
    logic [31:0] result;
    logic [31:0] instr;
  } md_entry_t;

  localparam logic [1:0] RESULT_SRC_MULDIV = 2'b11;

endpackage

// File: rtl/rv32_md_result_fifo.sv
// Mul/div completion FIFO with per-entry rd compare so a younger pipeline write can
// invalidate buffered results. WB_ARB_PERF_EN exposes a squash-event flag.
module rv32_md_result_fifo
  import rv32_wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     i_push,
  input  logic [4:0]               i_rd,
  input  logic [31:0]              i_result,
  input  logic [31:0]              i_instr,
  input  logic                     i_pop,
  input  logic                     i_squash,
  input  logic [4:0]               i_squashRd,
  output md_entry_t                o_head,
  output logic [$clog2(DEPTH):0]   o_count
`ifdef WB_ARB_PERF_EN
  ,
  output logic                     o_squashed
`endif
);

  localparam int AW = $clog2(DEPTH);

  md_entry_t        r_mem [DEPTH];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic [AW:0]      w_count;
  logic [DEPTH-1:0] w_hit;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign w_count = r_wptr - r_rptr;
  assign o_count = w_count;
  assign o_head  = (w_count != '0) ? r_mem[r_rptr[AW-1:0]] : '0;

`ifdef WB_ARB_PERF_EN
  assign o_squashed = |w_hit;
`endif

  always_comb begin
    w_hit = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_hit[i] = i_squash && r_mem[i].valid && (r_mem[i].rd == i_squashRd);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_hit[i]) begin
          r_mem[i].valid <= 1'b0;
        end
      end
      if (i_pop) begin
        r_mem[r_rptr[AW-1:0]].valid <= 1'b0;
        r_rptr <= r_rptr + (AW+1)'(1);
      end
      // The push slot is never occupied, so it cannot collide with a squash or pop.
      if (i_push) begin
        r_mem[r_wptr[AW-1:0]] <= '{valid: 1'b1, rd: i_rd, result: i_result, instr: i_instr};
        r_wptr <= r_wptr + (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/rv32_wb_port_arbiter.sv
// Shares the register-file write port between the pipeline and buffered mul/div results.
// Optional WB_ARB_PERF_EN adds saturating stall and squash counters.
module rv32_wb_port_arbiter
  import rv32_wb_pkg::*;
#(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        pipe_wb_valid_i,
  input  logic        pipe_reg_write_i,
  input  logic [4:0]  pipe_rd_i,
  input  logic        md_valid_i,
  output logic        md_ready_o,
  input  logic [4:0]  md_rd_i,
  input  logic [31:0] md_result_i,
  input  logic [31:0] md_instr_i,
  output logic        instr_source_o,
  output logic        result_source_ovr_o,
  output logic [31:0] muldiv_instr_o,
  output logic [31:0] mul_div_result_o,
  output logic        rf_we_o,
  output logic [4:0]  rf_rd_o,
  output logic        pipe_stall_o
`ifdef WB_ARB_PERF_EN
  ,
  output logic [31:0] perf_stall_cnt_o,
  output logic [31:0] perf_squash_cnt_o
`endif
);

  localparam int AW = $clog2(DEPTH);

  wb_arb_state_e r_state;
  logic [3:0]    r_waitCnt;
  logic          r_mdReady;

  md_entry_t     w_head;
  logic [AW:0]   w_count;
  logic [AW:0]   w_countNext;
  logic          w_pipeWrite;
  logic          w_push;
  logic          w_pop;
  logic          w_grantMd;
  logic          w_pipeOwns;
  logic          w_squash;
  logic          w_forceNext;
  logic [1:0]    w_resultSel;
`ifdef WB_ARB_PERF_EN
  logic          w_squashed;
`endif

  assign w_pipeWrite = pipe_wb_valid_i && pipe_reg_write_i;
  // Results targeting x0 are acknowledged but never buffered.
  assign w_push      = md_valid_i && r_mdReady && (md_rd_i != 5'd0);
  assign w_squash    = w_pipeOwns && w_pipeWrite;

  rv32_md_result_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .i_push     (w_push),
    .i_rd       (md_rd_i),
    .i_result   (md_result_i),
    .i_instr    (md_instr_i),
    .i_pop      (w_pop),
    .i_squash   (w_squash),
    .i_squashRd (pipe_rd_i),
    .o_head     (w_head),
    .o_count    (w_count)
`ifdef WB_ARB_PERF_EN
    ,
    .o_squashed (w_squashed)
`endif
  );

  always_comb begin
    w_grantMd  = 1'b0;
    w_pop      = 1'b0;
    w_pipeOwns = 1'b0;
    case (r_state)
      IDLE: w_pipeOwns = 1'b1;
      PENDING: begin
        // A squashed head drains silently while the pipeline keeps the port.
        if (!w_head.valid) begin
          w_pop      = (w_count != '0);
          w_pipeOwns = 1'b1;
        end else if (!w_pipeWrite) begin
          w_grantMd = 1'b1;
          w_pop     = 1'b1;
        end else begin
          w_pipeOwns = 1'b1;
        end
      end
      FORCE: begin
        w_pop     = (w_count != '0);
        w_grantMd = w_head.valid;
      end
      default: w_pipeOwns = 1'b1;
    endcase
  end

  // Starving head is forced only if this cycle's pipeline write does not squash it.
  assign w_forceNext = (r_state == PENDING) && w_head.valid && w_pipeWrite &&
                       (w_head.rd != pipe_rd_i) &&
                       (r_waitCnt + 4'd1 == 4'(STARVE_LIMIT));
  assign w_countNext = w_count + (AW+1)'(w_push) - (AW+1)'(w_pop);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= IDLE;
      r_waitCnt <= '0;
      r_mdReady <= 1'b1;
    end else begin
      r_mdReady <= (w_countNext != (AW+1)'(DEPTH));
      if (w_pop) begin
        r_waitCnt <= '0;
      end else if ((r_state == PENDING) && w_head.valid && w_pipeWrite) begin
        r_waitCnt <= r_waitCnt + 4'd1;
      end
      if (w_forceNext) begin
        r_state <= FORCE;
      end else if (w_countNext != '0) begin
        r_state <= PENDING;
      end else begin
        r_state <= IDLE;
      end
    end
  end

  assign w_resultSel         = w_grantMd ? RESULT_SRC_MULDIV : 2'b00;
  assign instr_source_o      = w_grantMd;
  assign result_source_ovr_o = (w_resultSel == RESULT_SRC_MULDIV);
  assign rf_we_o             = w_grantMd || (w_pipeOwns && w_pipeWrite);
  assign rf_rd_o             = w_grantMd ? w_head.rd : (w_pipeOwns ? pipe_rd_i : 5'd0);
  assign muldiv_instr_o      = w_head.instr;
  assign mul_div_result_o    = w_head.result;
  assign pipe_stall_o        = (r_state == FORCE);
  assign md_ready_o          = r_mdReady;

`ifdef WB_ARB_PERF_EN
  logic [31:0] r_perfStall;
  logic [31:0] r_perfSquash;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_perfStall  <= '0;
      r_perfSquash <= '0;
    end else begin
      if (pipe_stall_o && (r_perfStall != '1)) begin
        r_perfStall <= r_perfStall + 32'd1;
      end
      if (w_squashed && (r_perfSquash != '1)) begin
        r_perfSquash <= r_perfSquash + 32'd1;
      end
    end
  end

  assign perf_stall_cnt_o  = r_perfStall;
  assign perf_squash_cnt_o = r_perfSquash;
`endif

endmodule
